// File: rtl/display_scan_scheduler.sv
// rtl/display_scan_scheduler.sv - 4-digit common-anode 7-segment scan scheduler with dead time and frame-synchronous shadow load
// Optional leading-zero suppression: define DISPLAY_LEADING_ZERO_BLANK_EN
module display_scan_scheduler #(
   parameter int DIV         = 50000,
   parameter int ON_TICKS    = 4,
   parameter int BLANK_TICKS = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic [3:0]  dp,
   input  logic [3:0]  digit_en,
   input  logic        load,
   output logic [3:0]  anode,
   output logic [6:0]  seg,
   output logic        dp_n,
   output logic [1:0]  choice,
   output logic        pending,
   output logic        frame_done
);

   localparam int PW   = $clog2(DIV);
   localparam int SMAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
   localparam int SW   = $clog2(SMAX + 1);

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_ON    = 1'b1;

   localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
   localparam logic [SW-1:0] ON_LAST    = SW'(ON_TICKS - 1);
   localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_TICKS - 1);

   logic [PW-1:0] pre_cnt;
   logic          tick;
   logic [0:0]    state;
   logic [SW-1:0] slot_cnt;
   logic          on_end;
   logic          boundary;

   logic [15:0]   act_value;
   logic [3:0]    act_dp;
   logic [3:0]    act_en;
   logic [15:0]   shd_value;
   logic [3:0]    shd_dp;
   logic [3:0]    shd_en;

   logic [3:0]    cur_digit;
   logic          cur_dp;
   logic          cur_en;
   logic          suppress;
   logic          lit;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign tick     = (pre_cnt == PRE_LAST);
   assign on_end   = tick && (state == ST_ON) && (slot_cnt == ON_LAST);
   assign boundary = on_end && (choice == 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      end
   end

   // Slot counter only moves on ticks; each phase lasts exactly its tick count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_BLANK;
         slot_cnt <= '0;
         choice   <= 2'd0;
      end else if (tick) begin
         if (state == ST_BLANK) begin
            if (slot_cnt == BLANK_LAST) begin
               state    <= ST_ON;
               slot_cnt <= '0;
            end else begin
               slot_cnt <= slot_cnt + 1'b1;
            end
         end else begin
            if (slot_cnt == ON_LAST) begin
               state    <= ST_BLANK;
               slot_cnt <= '0;
               choice   <= choice + 1'b1;
            end else begin
               slot_cnt <= slot_cnt + 1'b1;
            end
         end
      end
   end

   // A load coinciding with the boundary bypasses the shadow so it is not lost for a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shd_value  <= '0;
         shd_dp     <= '0;
         shd_en     <= '0;
         act_value  <= '0;
         act_dp     <= '0;
         act_en     <= '0;
         pending    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= boundary;
         if (load) begin
            shd_value <= value;
            shd_dp    <= dp;
            shd_en    <= digit_en;
         end
         if (boundary) begin
            pending <= 1'b0;
            if (load) begin
               act_value <= value;
               act_dp    <= dp;
               act_en    <= digit_en;
            end else if (pending) begin
               act_value <= shd_value;
               act_dp    <= shd_dp;
               act_en    <= shd_en;
            end
         end else if (load) begin
            pending <= 1'b1;
         end
      end
   end

   always_comb begin
      cur_digit = 4'h0;
      cur_dp    = 1'b0;
      cur_en    = 1'b0;
      case (choice)
         2'd0: begin cur_digit = act_value[15:12]; cur_dp = act_dp[3]; cur_en = act_en[3]; end
         2'd1: begin cur_digit = act_value[11:8];  cur_dp = act_dp[2]; cur_en = act_en[2]; end
         2'd2: begin cur_digit = act_value[7:4];   cur_dp = act_dp[1]; cur_en = act_en[1]; end
         default: begin cur_digit = act_value[3:0]; cur_dp = act_dp[0]; cur_en = act_en[0]; end
      endcase
   end

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
   logic [2:0] zero_run;

   // zero_run[i]: slot i and every slot to its left hold zero; the rightmost slot is never suppressed.
   always_comb begin
      zero_run[0] = (act_value[15:12] == 4'h0);
      zero_run[1] = zero_run[0] && (act_value[11:8] == 4'h0);
      zero_run[2] = zero_run[1] && (act_value[7:4] == 4'h0);
      suppress    = 1'b0;
      case (choice)
         2'd0: suppress = zero_run[0];
         2'd1: suppress = zero_run[1];
         2'd2: suppress = zero_run[2];
         default: suppress = 1'b0;
      endcase
   end
`else
   assign suppress = 1'b0;
`endif

   assign lit = (state == ST_ON) && cur_en && !suppress;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         anode <= 4'b1111;
         seg   <= 7'b1111111;
         dp_n  <= 1'b1;
      end else if (lit) begin
         anode <= ~(4'b1000 >> choice);
         seg   <= hex7(cur_digit);
         dp_n  <= ~cur_dp;
      end else begin
         anode <= 4'b1111;
         seg   <= 7'b1111111;
         dp_n  <= 1'b1;
      end
   end

endmodule
